gb_rd_arbiter: RTL and testbench
================================

GB_RD_ARBITER -- requirements
Module: gb_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of read requesters sharing one global-buffer SRAM read port.
REQ-002 Parameter SRAM_ADDRWIDTH, default 9: SRAM address width.
REQ-003 Parameter DATA_WIDTH, default 128: SRAM read data width.
REQ-004 Parameter MAX_BURST, default 16: read limit per grant when the burst limit is compiled in.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk  input  1: clock; all state changes on the rising edge.
REQ-007 Port rst  input  1: synchronous, active-high reset.
REQ-008 Port req  input  NUM_REQ: per-requester read request, held high while the requester has reads to issue.
REQ-009 Port last  input  NUM_REQ: marks the requester's final read of its current burst; valid only with req.
REQ-010 Port addr_in  input  NUM_REQ*SRAM_ADDRWIDTH: flattened read addresses; requester i at bits [i*SRAM_ADDRWIDTH +: SRAM_ADDRWIDTH].
REQ-011 Port gnt  output  NUM_REQ: one-hot grant, registered.
REQ-012 Port sram_rd_en  output  1: SRAM read enable.
REQ-013 Port sram_addr  output  SRAM_ADDRWIDTH: SRAM read address.
REQ-014 Port sram_rdata  input  DATA_WIDTH: SRAM read data, valid one cycle after sram_rd_en.
REQ-015 Port rdata_val  output  NUM_REQ: one-hot return strobe to the requester that issued the read.
REQ-016 Port rdata  output  DATA_WIDTH: pass-through of sram_rdata.
REQ-017 Port busy  output  1: high while in GRANT or while a read return is pending.

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-019 IDLE: if any req is high, the owner SHALL be chosen round-robin, searching upward from rr_ptr with wrap at NUM_REQ; the next state is GRANT and gnt[owner] is 1 from the next cycle.
REQ-020 IDLE with no req: the FSM SHALL stay in IDLE with gnt = 0.
REQ-021 GRANT with req[owner]=1: sram_rd_en = 1 and sram_addr = addr_in slice of owner, combinationally in the same cycle.
REQ-022 GRANT with req[owner]=1 and last[owner]=1: the read SHALL issue, then the next state is IDLE and rr_ptr = (owner+1) mod NUM_REQ.
REQ-023 GRANT with req[owner]=0 (abort): no read SHALL issue, the next state is IDLE, and rr_ptr = (owner+1) mod NUM_REQ.
REQ-024 Every grant change SHALL incur exactly one IDLE arbitration cycle; back-to-back grants to different owners are separated by one cycle with sram_rd_en = 0.
REQ-025 rdata_val[k] SHALL be 1 exactly one cycle after a read issued for owner k, with rdata = sram_rdata in that cycle; rdata_val is 0 otherwise.
REQ-026 Requests from non-owners SHALL be ignored during GRANT; requesters must hold req until granted.
REQ-027 The per-grant read counter burst_cnt (width clog2(MAX_BURST+1)) SHALL clear on entry to GRANT and increment on each issued read.
REQ-028 sram_rd_en, gnt and rdata_val SHALL each be one-hot or zero in every cycle.

Reset
REQ-029 While rst is high, the next clock SHALL force state = IDLE, gnt = 0, rr_ptr = 0, burst_cnt = 0, rdata_val = 0 and busy = 0.
REQ-030 Reset asserted mid-burst SHALL drop the grant; the return strobe of a read issued in the reset cycle SHALL be suppressed.
REQ-031 sram_rd_en and sram_addr SHALL be 0 in the cycle after reset.

Configuration
REQ-032 Macro GB_ARB_BURST_LIMIT_EN defined: when a read issues with burst_cnt = MAX_BURST-1 and any other req is high, the FSM SHALL return to IDLE after that read and advance rr_ptr; the preempted requester keeps req high and is re-arbitrated.
REQ-033 Macro GB_ARB_BURST_LIMIT_EN undefined: a grant SHALL be held until last or abort regardless of burst length, and burst_cnt logic SHALL be absent.

Verification
REQ-034 After reset, req=3'b001 with addr 5,6,7 and last on the 3rd read -> gnt=001 one cycle later; sram_addr 5,6,7 on consecutive cycles; rdata_val[0] on 3 cycles, each lagging by 1; then IDLE.
REQ-035 req=3'b111 held, each requester issuing 1-read bursts -> grant order 0,1,2,0 with one idle cycle between grants.
REQ-036 Owner 1 drops req mid-burst without last -> no read that cycle; next grant goes to 2 when pending.
REQ-037 With GB_ARB_BURST_LIMIT_EN and MAX_BURST=4, req0 with a 10-read burst and req1 pending -> 4 reads for 0, then grant to 1, then 0 resumes; without the macro -> 10 reads for 0 first.
REQ-038 rst asserted in the cycle of a read -> next cycle gnt=0, rdata_val=0, busy=0; after release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/gb_rd_arbiter.sv
// ---------------------------------------------------------------------------
// gb_rd_arbiter
//
// Round-robin arbiter that lets NUM_REQ read requesters share the single read
// port of the global-buffer SRAM. A requester wins a grant and keeps it for a
// whole burst. The burst ends when the requester flags `last`, or when it drops
// `req` (an abort). Every change of owner goes through one IDLE arbitration
// cycle. The SRAM returns data one cycle after each read. The block strobes
// that data back to the requester that issued the read.
//
// Optional feature (compile-time macro GB_ARB_BURST_LIMIT_EN):
//   This macro adds a per-grant read counter. When the owner has issued
//   MAX_BURST reads and some other requester is waiting, the owner is
//   preempted after its MAX_BURST-th read. The owner keeps `req` high and is
//   arbitrated again later. Without the macro, a grant lasts until `last` or
//   an abort, and the counter is not built.
//
// Ports
//   clk         in   1                     clock, rising edge
//   rst         in   1                     synchronous active-high reset
//   req         in   NUM_REQ               per-requester read request
//   last        in   NUM_REQ               final read of current burst
//   addr_in     in   NUM_REQ*SRAM_ADDRWIDTH flattened per-requester addresses
//   gnt         out  NUM_REQ               registered one-hot grant
//   sram_rd_en  out  1                     SRAM read enable
//   sram_addr   out  SRAM_ADDRWIDTH        SRAM read address
//   sram_rdata  in   DATA_WIDTH            SRAM read data (1-cycle latency)
//   rdata_val   out  NUM_REQ               one-hot read-return strobe
//   rdata       out  DATA_WIDTH            read data, straight from SRAM
//   busy        out  1                     in GRANT or read return pending
// ---------------------------------------------------------------------------
module gb_rd_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int SRAM_ADDRWIDTH = 9,
  parameter int DATA_WIDTH     = 128,
  parameter int MAX_BURST      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                last,
  input  logic [NUM_REQ*SRAM_ADDRWIDTH-1:0] addr_in,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              sram_rd_en,
  output logic [SRAM_ADDRWIDTH-1:0]         sram_addr,
  input  logic [DATA_WIDTH-1:0]             sram_rdata,
  output logic [NUM_REQ-1:0]                rdata_val,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]       rval_q, rval_d;

  logic [SRAM_ADDRWIDTH-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]        owner_oh;
  logic [IDX_W:0]            cand_sum [NUM_REQ];
  logic [IDX_W-1:0]          cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]        cand_req;
  logic [IDX_W-1:0]          pick_idx;
  logic [IDX_W-1:0]          owner_inc;
  logic                      any_req;
  logic                      rd_issue;
  logic                      burst_hit;

  // -------------------------------------------------------------------------
  // Per-requester views: unpacked address slices, owner decode, and the
  // rotated candidate order for the round-robin search.
  // Search slot gi looks at requester (rr_ptr + gi) mod NUM_REQ. Both terms
  // are below NUM_REQ, so one conditional subtract gives the wrap.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi] = addr_in[gi*SRAM_ADDRWIDTH +: SRAM_ADDRWIDTH];
      assign owner_oh[gi] = (owner_q == IDX_W'(gi));
      assign cand_sum[gi] = {1'b0, rr_ptr_q} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                          : IDX_W'(cand_sum[gi]);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // The loop scans the slots from highest to lowest. The lowest requesting
  // slot is assigned last, so it wins. That slot is the first requester at
  // or after rr_ptr.
  always_comb begin
    pick_idx = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        pick_idx = cand_idx[i];
      end
    end
  end

  assign any_req   = |req;
  assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // A read issues only while the current owner still asserts req. An owner
  // that drops req in GRANT is treated as an abort, and no read goes out.
  assign rd_issue  = (state_q == GRANT) && req[owner_q];

  // -------------------------------------------------------------------------
  // Optional burst limit
  // -------------------------------------------------------------------------
`ifdef GB_ARB_BURST_LIMIT_EN
  localparam int BCW = $clog2(MAX_BURST + 1);

  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic           other_req;

  assign other_req = |(req & ~owner_oh);

  // The comparison is >= instead of ==. If a requester starts waiting after
  // the owner has already passed the limit, the owner is still preempted on
  // its next read. The counter saturates at MAX_BURST so it never wraps.
  assign burst_hit = rd_issue && other_req &&
                     (burst_cnt_q >= BCW'(MAX_BURST - 1));

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE) begin
      burst_cnt_d = '0;
    end else if (rd_issue && (burst_cnt_q != BCW'(MAX_BURST))) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
        end
      end
      GRANT: begin
        // The grant ends on the last read, on an abort, or on a burst-limit
        // preemption. All three cases advance the pointer past the owner.
        if (!req[owner_q] || last[owner_q] || burst_hit) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
          gnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // The return strobe goes to whoever issued this cycle's read, one cycle
  // later. Reset clears the pending strobe, so a read issued in the reset
  // cycle produces no return strobe.
  assign rval_d = rd_issue ? owner_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      rval_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      rval_q   <= rval_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign gnt        = gnt_q;
  assign sram_rd_en = rd_issue;
  assign sram_addr  = rd_issue ? addr_arr[owner_q] : '0;
  assign rdata_val  = rval_q;
  assign rdata      = sram_rdata;
  assign busy       = (state_q == GRANT) || (|rval_q);

endmodule

// File: tb/tb_gb_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gb_rd_arbiter
//
// Directed bench for gb_rd_arbiter (NUM_REQ=3, SRAM_ADDRWIDTH=9,
// DATA_WIDTH=128, MAX_BURST=4).
//
// The SRAM is modelled as returning 0xCAFE0000 + address one cycle after
// each read. Inputs change 1 time unit after the rising edge. Outputs are
// sampled on the falling edge.
//
// The burst-limit scenario expects different results depending on whether
// GB_ARB_BURST_LIMIT_EN is defined.
// ---------------------------------------------------------------------------
module tb_gb_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 9;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*AW-1:0] addr_in;
  logic [N-1:0]    gnt;
  logic            sram_rd_en;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_rdata = '0;
  logic [N-1:0]    rdata_val;
  logic [DW-1:0]   rdata;
  logic            busy;

  logic [AW-1:0]   a0, a1, a2;
  assign addr_in = {a2, a1, a0};

  always #5 clk = ~clk;

  // Simple SRAM with a registered read.
  always @(posedge clk) begin
    if (sram_rd_en) begin
      sram_rdata <= 128'hCAFE0000 + 128'(sram_addr);
    end
  end

  gb_rd_arbiter #(
    .NUM_REQ       (N),
    .SRAM_ADDRWIDTH(AW),
    .DATA_WIDTH    (DW),
    .MAX_BURST     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .addr_in   (addr_in),
    .gnt       (gnt),
    .sram_rd_en(sram_rd_en),
    .sram_addr (sram_addr),
    .sram_rdata(sram_rdata),
    .rdata_val (rdata_val),
    .rdata     (rdata),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Expected per-cycle values for the all-requesting round-robin run.
  logic [2:0]    t2_g [8];
  logic [2:0]    t2_v [8];
  logic [AW-1:0] t2_a [8];

  // Burst scenario: expected reads as {grant, address}, plus the log of
  // observed reads.
  logic [2:0]    exp_g [11];
  logic [AW-1:0] exp_a [11];
  logic [2:0]    log_g [16];
  logic [AW-1:0] log_a [16];
  int            n0, n1, nr;

  initial begin
    t2_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    t2_v = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    t2_a = '{9'h000, 9'h010, 9'h000, 9'h011, 9'h000, 9'h012, 9'h000, 9'h010};
`ifdef GB_ARB_BURST_LIMIT_EN
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001,
              3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    exp_a = '{9'h040, 9'h041, 9'h042, 9'h043, 9'h050, 9'h044,
              9'h045, 9'h046, 9'h047, 9'h048, 9'h049};
`else
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
              3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    exp_a = '{9'h040, 9'h041, 9'h042, 9'h043, 9'h044, 9'h045,
              9'h046, 9'h047, 9'h048, 9'h049, 9'h050};
`endif
    for (int k = 0; k < 16; k++) begin
      log_g[k] = '0;
      log_a[k] = '0;
    end

    // ---------------- reset ----------------
    rst = 1'b1; req = '0; last = '0; a0 = '0; a1 = '0; a2 = '0;
    cyc(); cyc();
    mid();
    chk("rst_gnt",   128'(gnt),        128'h0);
    chk("rst_rval",  128'(rdata_val),  128'h0);
    chk("rst_busy",  128'(busy),       128'h0);
    chk("rst_rden",  128'(sram_rd_en), 128'h0);
    chk("rst_addr",  128'(sram_addr),  128'h0);
    cyc();

    // ---------------- single 3-read burst from requester 0 ----------------
    rst = 1'b0; req = 3'b001; a0 = 9'd5;
    mid();
    chk("t1_arb_gnt",  128'(gnt),        128'h0);
    chk("t1_arb_rden", 128'(sram_rd_en), 128'h0);
    cyc();
    mid();
    chk("t1_r0_gnt",   128'(gnt),        128'h1);
    chk("t1_r0_rden",  128'(sram_rd_en), 128'h1);
    chk("t1_r0_addr",  128'(sram_addr),  128'd5);
    chk("t1_r0_rval",  128'(rdata_val),  128'h0);
    cyc();
    a0 = 9'd6;
    mid();
    chk("t1_r1_addr",  128'(sram_addr),  128'd6);
    chk("t1_r1_rval",  128'(rdata_val),  128'h1);
    chk("t1_r1_rdata", rdata,            128'hCAFE0005);
    cyc();
    a0 = 9'd7; last = 3'b001;
    mid();
    chk("t1_r2_addr",  128'(sram_addr),  128'd7);
    chk("t1_r2_rval",  128'(rdata_val),  128'h1);
    chk("t1_r2_rdata", rdata,            128'hCAFE0006);
    chk("t1_r2_busy",  128'(busy),       128'h1);
    cyc();
    req = '0; last = '0;
    mid();
    chk("t1_end_gnt",  128'(gnt),        128'h0);
    chk("t1_end_rden", 128'(sram_rd_en), 128'h0);
    chk("t1_end_rval", 128'(rdata_val),  128'h1);
    chk("t1_end_rdata", rdata,           128'hCAFE0007);
    chk("t1_end_busy", 128'(busy),       128'h1);
    cyc();
    mid();
    chk("t1_idle_rval", 128'(rdata_val), 128'h0);
    chk("t1_idle_busy", 128'(busy),      128'h0);
    cyc();

    // ---------------- all three requesting, 1-read bursts ----------------
    rst = 1'b1;
    mid();
    cyc();
    rst = 1'b0; req = 3'b111; last = 3'b111;
    a0 = 9'h010; a1 = 9'h011; a2 = 9'h012;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk($sformatf("t2_gnt%0d", i),  128'(gnt),        128'(t2_g[i]));
      chk($sformatf("t2_rden%0d", i), 128'(sram_rd_en), 128'(|t2_g[i]));
      chk($sformatf("t2_rval%0d", i), 128'(rdata_val),  128'(t2_v[i]));
      if (t2_g[i] != 3'b000) begin
        chk($sformatf("t2_addr%0d", i), 128'(sram_addr), 128'(t2_a[i]));
      end
      cyc();
    end
    req = '0; last = '0;
    mid();
    chk("t2_tail_rval", 128'(rdata_val), 128'h1);
    cyc();

    // ---------------- abort by owner 1, then grant to 2 ----------------
    req = 3'b010; last = '0; a1 = 9'h021;
    mid();
    chk("t3_arb_gnt",   128'(gnt),        128'h0);
    cyc();
    mid();
    chk("t3_g1_gnt",    128'(gnt),        128'h2);
    chk("t3_g1_rden",   128'(sram_rd_en), 128'h1);
    chk("t3_g1_addr",   128'(sram_addr),  128'h021);
    cyc();
    req = 3'b100; a2 = 9'h032; last = 3'b100;
    mid();
    chk("t3_abort_rden", 128'(sram_rd_en), 128'h0);
    chk("t3_abort_gnt",  128'(gnt),        128'h2);
    chk("t3_abort_rval", 128'(rdata_val),  128'h2);
    cyc();
    mid();
    chk("t3_idle_gnt",  128'(gnt),        128'h0);
    chk("t3_idle_rval", 128'(rdata_val),  128'h0);
    chk("t3_idle_rden", 128'(sram_rd_en), 128'h0);
    cyc();
    mid();
    chk("t3_g2_gnt",    128'(gnt),        128'h4);
    chk("t3_g2_rden",   128'(sram_rd_en), 128'h1);
    chk("t3_g2_addr",   128'(sram_addr),  128'h032);
    cyc();
    req = '0; last = '0;
    mid();
    chk("t3_g2_rval",   128'(rdata_val),  128'h4);
    cyc();

    // ---------------- 10-read burst from 0 with 1 pending ----------------
    n0 = 0; n1 = 0; nr = 0;
    for (int c = 0; c < 60 && !(n0 == 10 && n1 == 1); c++) begin
      req  = {1'b0, (n1 < 1), (n0 < 10)};
      last = {1'b0, 1'b1, (n0 == 9)};
      a0   = 9'h040 + 9'(n0);
      a1   = 9'h050;
      mid();
      if (sram_rd_en) begin
        if (nr < 16) begin
          log_g[nr] = gnt;
          log_a[nr] = sram_addr;
        end
        nr++;
        if (gnt[0]) n0++;
        else if (gnt[1]) n1++;
      end
      cyc();
    end
    req = '0; last = '0;
    chk("t4_nreads", 128'(nr), 128'd11);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("t4_gnt%0d", k),  128'(log_g[k]), 128'(exp_g[k]));
      chk($sformatf("t4_addr%0d", k), 128'(log_a[k]), 128'(exp_a[k]));
    end
    cyc(); cyc();

    // ---------------- reset asserted during a read ----------------
    req = 3'b010; last = '0; a1 = 9'h061;
    mid();
    chk("t5_arb_gnt",  128'(gnt),        128'h0);
    cyc();
    rst = 1'b1;
    mid();
    chk("t5_rd_gnt",   128'(gnt),        128'h2);
    chk("t5_rd_rden",  128'(sram_rd_en), 128'h1);
    cyc();
    rst = 1'b0; req = 3'b101; last = 3'b101; a0 = 9'h070; a2 = 9'h072;
    mid();
    chk("t5_post_gnt",  128'(gnt),        128'h0);
    chk("t5_post_rval", 128'(rdata_val),  128'h0);
    chk("t5_post_busy", 128'(busy),       128'h0);
    chk("t5_post_rden", 128'(sram_rd_en), 128'h0);
    chk("t5_post_addr", 128'(sram_addr),  128'h0);
    cyc();
    mid();
    chk("t5_restart_gnt",  128'(gnt),       128'h1);
    chk("t5_restart_addr", 128'(sram_addr), 128'h070);
    cyc();
    req = '0; last = '0;
    mid();
    chk("t5_restart_rval", 128'(rdata_val), 128'h1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
